// File: rtl/sb64_inv.sv
// Inverse SB64 Simeck box: undoes the forward 8-round permutation for a latched rc vector.
// Default: two inverse rounds per clock. SB64_INV_ONE_ROUND_EN selects one round per clock.
module sb64_inv #(
    parameter int ROUNDS = 8,
    parameter int WORD   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*WORD-1:0]   x_in,
    input  logic [ROUNDS-1:0]   rc,
    output logic [2*WORD-1:0]   x_out,
    output logic                busy,
    output logic                valid
);

    localparam int KW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [KW-1:0] K_INIT = KW'(ROUNDS - 1);
`ifdef SB64_INV_ONE_ROUND_EN
    localparam logic [KW-1:0] K_STEP = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(0);
`else
    localparam logic [KW-1:0] K_STEP = KW'(2);
    localparam logic [KW-1:0] K_LAST = KW'(1);
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [2*WORD-1:0]   s_q, s_d;
    logic [ROUNDS-1:0]   rc_q, rc_d;
    logic [KW-1:0]       k_q, k_d;
    logic                valid_q, valid_d;
    logic [2*WORD-1:0]   s_a;
    logic [2*WORD-1:0]   s_rounds;

    // One inverse round: (L,R) -> (R, L ^ f(R) ^ c(b)).
    function automatic logic [2*WORD-1:0] inv_round(input logic [2*WORD-1:0] s, input logic b);
        logic [WORD-1:0] l;
        logic [WORD-1:0] r;
        logic [WORD-1:0] fr;
        l  = s[2*WORD-1:WORD];
        r  = s[WORD-1:0];
        fr = ({r[WORD-6:0], r[WORD-1:WORD-5]} & r) ^ {r[WORD-2:0], r[WORD-1]};
        return {r, l ^ fr ^ {{(WORD-1){1'b1}}, b}};
    endfunction

`ifdef SB64_INV_ONE_ROUND_EN
    always_comb begin
        s_a      = inv_round(s_q, rc_q[k_q]);
        s_rounds = s_a;
    end
`else
    logic [KW-1:0] k_m1;

    // Stage A consumes the higher round bit; stage B the next one down.
    always_comb begin
        k_m1     = k_q - KW'(1);
        s_a      = inv_round(s_q, rc_q[k_q]);
        s_rounds = inv_round(s_a, rc_q[k_m1]);
    end
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        rc_d    = rc_q;
        k_d     = k_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = x_in;
                    rc_d    = rc;
                    k_d     = K_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d = s_rounds;
                if (k_q == K_LAST) begin
                    k_d     = K_INIT;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q - K_STEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            rc_q    <= '0;
            k_q     <= K_INIT;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            rc_q    <= rc_d;
            k_q     <= k_d;
            valid_q <= valid_d;
        end
    end

    assign x_out = s_q;
    assign busy  = (state_q == RUN);
    assign valid = valid_q;

endmodule
